muldiv_sequencer: RTL
=====================

// Module: muldiv_sequencer
// PURPOSE
//  Iterative multiply/divide unit with sequencer, sitting beside the EX-stage ALU.
//  Runs MULT/MULTU/DIV/DIVU over WIDTH cycles using a shift-add / restoring-subtract datapath.
//  Holds the HI/LO result registers.
//  Stalls the pipeline through stall_req while an operation is in flight.
// PARAMETERS
//  WIDTH  32  operand width; HI and LO are each WIDTH bits; iteration count = WIDTH
// PORTS
//  clk       in   1      rising-edge clock
//  rst       in   1      synchronous, active-high reset
//  start     in   1      request to start the operation selected by op
//  op        in   2      00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//  rs_val    in   WIDTH  multiplicand / dividend
//  rt_val    in   WIDTH  multiplier / divisor
//  flush     in   1      abort the in-flight operation (pipeline flush)
//  busy      out  1      operation in flight (RUN or FIX state)
//  stall_req out  1      busy | (start & accepted); EX holds while high
//  done      out  1      one-cycle pulse; HI/LO updated this cycle
//  hi        out  WIDTH  HI register (product high half / remainder)
//  lo        out  WIDTH  LO register (product low half / quotient)
// BEHAVIOUR
//  Reset:
//   - state=IDLE; busy=0, done=0, hi=0, lo=0, iteration counter=0.
//   - Reset mid-operation abandons the operation.
//  States: IDLE -> RUN -> FIX -> DONE -> IDLE.
//  Accept:
//   - start is accepted when state is IDLE or DONE (back-to-back allowed).
//   - Operands and op are latched at the accepting edge.
//   - start in RUN or FIX is ignored and is not queued.
//  Timing (start high in cycle 0):
//   - RUN occupies cycles 1..WIDTH, one iteration per cycle, counter runs 0..WIDTH-1.
//   - FIX is cycle WIDTH+1: sign correction.
//   - DONE is cycle WIDTH+2: done=1 and hi/lo take the new result.
//   - State is IDLE in cycle WIDTH+3 unless a new start was accepted in DONE.
//   - busy=1 in cycles 1..WIDTH+1 only.
//  Signed ops (MULT, DIV):
//   - Iterate on magnitudes.
//   - Product is negated (2*WIDTH-bit two's complement) when the operand signs differ.
//   - Quotient is negated when the signs differ; remainder takes the dividend's sign.
//  Unsigned ops: no correction; FIX is still spent, so latency is fixed.
//  Divide by zero: lo=all ones, hi=rs_val (raw dividend, no sign fix); no exception, same latency.
//  DIV of most-negative / -1: lo=100..0, hi=0 (wraps, no trap).
//  Internal arithmetic:
//   - Multiply accumulator is WIDTH+1 bits, to hold the carry.
//   - Remainder register is WIDTH+1 bits.
//   - Every shift is logical on magnitudes.
//  flush:
//   - In RUN or FIX: state becomes IDLE next cycle, busy=0, no done pulse, hi/lo keep their old values.
//   - flush and start in the same cycle: flush wins and start is not accepted.
//   - flush in IDLE or DONE has no effect; the DONE-cycle result is already committed.
//  hi/lo change only in the DONE cycle or on reset.
// CONFIGURATION
//  MULDIV_DIVIDE_EN defined:
//   - DIVU and DIV are supported as described above.
//  MULDIV_DIVIDE_EN undefined:
//   - The divide datapath is removed.
//   - start with op[1]=1 is never accepted: busy, stall_req and done stay 0, hi/lo unchanged.
//   - Multiply behaviour and latency are unchanged.
// TESTING (WIDTH=32)
//  MULTU FFFFFFFF*FFFFFFFF, start in cycle 0
//   -> busy cycles 1..33; done in cycle 34; hi=FFFFFFFE, lo=00000001.
//  MULT -3*5
//   -> hi=FFFFFFFF, lo=FFFFFFF1.
//  DIV -7/2
//   -> lo=FFFFFFFD, hi=FFFFFFFF.
//  DIVU 5/0
//   -> lo=FFFFFFFF, hi=00000005, done still in cycle 34.
//  MULTU 7*6; flush in cycle 10; start again in cycle 10
//   -> busy=0 in cycle 11; no done; hi/lo unchanged; second start ignored.
//  Back-to-back: start MULTU 2*3, then start MULTU 4*5 in the DONE cycle
//   -> lo=6 in cycle 34, lo=20 in cycle 68.
//  Build without MULDIV_DIVIDE_EN; start DIVU
//   -> busy, stall_req and done stay 0 for 40 cycles.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and pipeline stall request.
// Define MULDIV_DIVIDE_EN to include the divide path; otherwise divide requests are never accepted.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    output logic             busy,
    output logic             stall_req,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
`ifdef MULDIV_DIVIDE_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             div_q, div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH:0]   acc_q, acc_d;

    logic             accept, rs_neg, rt_neg, ge;
    logic [WIDTH-1:0] rs_mag, rt_mag, quo, rem;
    logic [WIDTH:0]   sum, shifted;
    logic [2*WIDTH-1:0] prod;

    assign busy      = (state_q == RUN) | (state_q == FIX);
    assign done      = (state_q == DONE);
    assign stall_req = busy | accept;
    assign hi        = hi_q;
    assign lo        = lo_q;

    always_comb begin
        accept  = start & ~flush & ((state_q == IDLE) | (state_q == DONE)) & (DIV_EN | ~op[1]);
        rs_neg  = op[0] & rs_val[WIDTH-1];
        rt_neg  = op[0] & rt_val[WIDTH-1];
        rs_mag  = rs_neg ? -rs_val : rs_val;
        rt_mag  = rt_neg ? -rt_val : rt_val;
        // a_q is the multiplier/quotient shift register, acc_q the partial product/remainder
        sum     = acc_q + (a_q[0] ? {1'b0, b_q} : '0);
        shifted = {acc_q[WIDTH-1:0], a_q[WIDTH-1]};
        ge      = shifted >= {1'b0, b_q};
        prod    = neg_res_q ? -{acc_q[WIDTH-1:0], a_q} : {acc_q[WIDTH-1:0], a_q};
        quo     = (b_q == '0) ? '1 : (neg_res_q ? -a_q : a_q);
        rem     = neg_rem_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        if (accept) begin
            state_d   = RUN;
            cnt_d     = '0;
            div_d     = DIV_EN & op[1];
            neg_res_d = rs_neg ^ rt_neg;
            neg_rem_d = rs_neg;
            a_d       = op[1] ? rs_mag : rt_mag;
            b_d       = op[1] ? rt_mag : rs_mag;
            acc_d     = '0;
        end else if (busy & flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                RUN: begin
                    acc_d   = div_q ? (ge ? shifted - {1'b0, b_q} : shifted) : {1'b0, sum[WIDTH:1]};
                    a_d     = div_q ? {a_q[WIDTH-2:0], ge} : {sum[0], a_q[WIDTH-1:1]};
                    cnt_d   = cnt_q + 1'b1;
                    state_d = (cnt_q == LAST) ? FIX : RUN;
                end
                FIX: begin
                    state_d = DONE;
                    hi_d    = div_q ? rem : prod[2*WIDTH-1:WIDTH];
                    lo_d    = div_q ? quo : prod[WIDTH-1:0];
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            div_q     <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end
endmodule
